// File: rtl/sp_dt_rx.sv
// Receive buffer for the non-stallable Softplus(dt) pipe: show-ahead FIFO with upstream credits.
// Optional latency checker enabled by defining SP_DT_RX_LATCHK_EN.
module sp_dt_rx #(
  parameter int unsigned DW     = 16,
  parameter int unsigned H_TILE = 1,
  parameter int unsigned SP_LAT = 33,
  parameter int unsigned DEPTH  = 64
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       issue_i,
  output logic                       issue_ok_o,
  input  logic                       sp_valid_i,
  input  logic [H_TILE*DW-1:0]       sp_data_i,
  output logic                       m_valid_o,
  output logic [H_TILE*DW-1:0]       m_data_o,
  input  logic                       m_ready_i,
  output logic [$clog2(DEPTH):0]     occ_o,
  output logic [$clog2(DEPTH):0]     inflight_o,
  output logic                       ovf_o,
  output logic                       cred_err_o,
  output logic                       lat_err_o
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam int unsigned BW = H_TILE * DW;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [CW:0]   DEPTH_S = (CW+1)'(DEPTH);

  if (SP_LAT < 1 || DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_param
    $error("sp_dt_rx: SP_LAT must be >= 1 and DEPTH a power of 2 >= 2");
  end

  logic [BW-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] rd_next;
  logic [CW-1:0] occ;
  logic [CW-1:0] inflight;
  logic [BW-1:0] dout;
  logic          ovf;
  logic          cred_err;
  logic          full;
  logic          pop;
  logic          push;
  logic [CW:0]   credit_sum;

  always_comb begin
    full       = (occ == DEPTH_C);
    pop        = (occ != '0) & m_ready_i;
    push       = sp_valid_i & (~full | pop);
    rd_next    = rd_ptr + AW'(pop);
    credit_sum = {1'b0, occ} + {1'b0, inflight};
  end

  assign issue_ok_o = (credit_sum < DEPTH_S);
  assign m_valid_o  = (occ != '0);
  assign m_data_o   = dout;
  assign occ_o      = occ;
  assign inflight_o = inflight;
  assign ovf_o      = ovf;
  assign cred_err_o = cred_err;

  always_ff @(posedge clk) begin
    if (!rst && push) begin
      mem[wr_ptr] <= sp_data_i;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      occ      <= '0;
      inflight <= '0;
      dout     <= '0;
      ovf      <= 1'b0;
      cred_err <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      rd_ptr <= rd_next;

      case ({push, pop})
        2'b10:   occ <= occ + CW'(1);
        2'b01:   occ <= occ - CW'(1);
        default: occ <= occ;
      endcase

      case ({issue_i, sp_valid_i})
        2'b10: begin
          if (inflight != DEPTH_C) begin
            inflight <= inflight + CW'(1);
          end
        end
        2'b01: begin
          if (inflight != '0) begin
            inflight <= inflight - CW'(1);
          end
        end
        default: inflight <= inflight;
      endcase

      if ((issue_i & ~issue_ok_o) | (sp_valid_i & (inflight == '0))) begin
        cred_err <= 1'b1;
      end
      if (sp_valid_i & full & ~pop) begin
        ovf <= 1'b1;
      end

      // Output register tracks the head: take the incoming beat when it becomes
      // the new head (FIFO empty after this cycle's pop), else advance on pop.
      if (push && (wr_ptr == rd_next)) begin
        dout <= sp_data_i;
      end else if (pop) begin
        dout <= mem[rd_next];
      end
    end
  end

`ifdef SP_DT_RX_LATCHK_EN
  logic [SP_LAT-1:0] lat_sr;
  logic              lat_err;

  always_ff @(posedge clk) begin
    if (rst) begin
      lat_sr  <= '0;
      lat_err <= 1'b0;
    end else begin
      lat_sr <= SP_LAT'({lat_sr, issue_i});
      if (sp_valid_i != lat_sr[SP_LAT-1]) begin
        lat_err <= 1'b1;
      end
    end
  end

  assign lat_err_o = lat_err;
`else
  assign lat_err_o = 1'b0;
`endif

endmodule
